// File: rtl/register_scoreboard.sv
// Per-register pending-write scoreboard: counts in-flight writers per register
// between issue and writeback and raises a stall request for ID-stage sources.
module register_scoreboard #(
    parameter int NUM_REGS    = 16,
    parameter int CNT_W       = 2,
    parameter int MAX_PENDING = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  logic                issue_wb_en,
    input  logic [3:0]          issue_dest,
    input  logic                retire_valid,
    input  logic                retire_wb_en,
    input  logic [3:0]          retire_dest,
    input  logic [3:0]          src1,
    input  logic [3:0]          src2,
    input  logic                two_src,
    output logic                hazard_detected,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic                overflow_err,
    output logic                underflow_err
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PENDING);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0]    cnt      [NUM_REGS];
    logic [CNT_W-1:0]    cnt_next [NUM_REGS];
    logic [NUM_REGS-1:0] busy_next;
    logic                overflow_next;
    logic                underflow_next;
    logic                issue_ev;
    logic                retire_ev;
    logic                same_reg;

    assign issue_ev  = issue_valid && issue_wb_en;
    assign retire_ev = retire_valid && retire_wb_en;
    assign same_reg  = issue_ev && retire_ev && (issue_dest == retire_dest);

    // A matched issue/retire on one register cancels out, even at the limits.
    always_comb begin
        cnt_next       = cnt;
        overflow_next  = overflow_err;
        underflow_next = underflow_err;
        busy_next      = '0;

        if (issue_ev && !same_reg) begin
            if (cnt[issue_dest] == MAX_CNT) begin
                overflow_next = 1'b1;
            end else begin
                cnt_next[issue_dest] = cnt[issue_dest] + ONE;
            end
        end

        if (retire_ev && !same_reg) begin
            if (cnt[retire_dest] == '0) begin
                underflow_next = 1'b1;
            end else begin
                cnt_next[retire_dest] = cnt[retire_dest] - ONE;
            end
        end

        for (int r = 0; r < NUM_REGS; r++) begin
            busy_next[r] = |cnt_next[r];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
            busy_mask     <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            cnt           <= cnt_next;
            busy_mask     <= busy_next;
            overflow_err  <= overflow_next;
            underflow_err <= underflow_next;
        end
    end

    // busy_mask mirrors the registered counters, so it serves as the hazard lookup.
    assign hazard_detected = busy_mask[src1] || (two_src && busy_mask[src2]);

endmodule

// File: tb/tb_register_scoreboard.sv
// Directed table-driven bench for register_scoreboard plus hand-written
// sequences for same-cycle hazard timing and write-enable gating.
module tb_register_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic        issue_wb_en;
    logic [3:0]  issue_dest;
    logic        retire_valid;
    logic        retire_wb_en;
    logic [3:0]  retire_dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        two_src;
    logic        hazard_detected;
    logic [15:0] busy_mask;
    logic        overflow_err;
    logic        underflow_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        bit          rst;
        int          iss;
        int          ret;
        logic [3:0]  s1;
        logic [3:0]  s2;
        bit          two;
        logic        eh;
        logic [15:0] eb;
        logic        eo;
        logic        eu;
    } vec_t;

    vec_t vecs[$];

    register_scoreboard #(
        .NUM_REGS    (16),
        .CNT_W       (2),
        .MAX_PENDING (3)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .issue_valid     (issue_valid),
        .issue_wb_en     (issue_wb_en),
        .issue_dest      (issue_dest),
        .retire_valid    (retire_valid),
        .retire_wb_en    (retire_wb_en),
        .retire_dest     (retire_dest),
        .src1            (src1),
        .src2            (src2),
        .two_src         (two_src),
        .hazard_detected (hazard_detected),
        .busy_mask       (busy_mask),
        .overflow_err    (overflow_err),
        .underflow_err   (underflow_err)
    );

    always #5 clk = ~clk;

    // iss/ret of -1 means no event on that side this cycle.
    function automatic vec_t mk(input string name, input bit r, input int iss, input int ret,
                                input int s1, input int s2, input bit two,
                                input logic eh, input logic [15:0] eb,
                                input logic eo, input logic eu);
        vec_t v;
        v.name = name; v.rst = r; v.iss = iss; v.ret = ret;
        v.s1 = 4'(s1); v.s2 = 4'(s2); v.two = two;
        v.eh = eh; v.eb = eb; v.eo = eo; v.eu = eu;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst          = v.rst;
        issue_valid  = (v.iss >= 0);
        issue_wb_en  = (v.iss >= 0);
        issue_dest   = (v.iss >= 0) ? 4'(v.iss) : 4'd0;
        retire_valid = (v.ret >= 0);
        retire_wb_en = (v.ret >= 0);
        retire_dest  = (v.ret >= 0) ? 4'(v.ret) : 4'd0;
        src1         = v.s1;
        src2         = v.s2;
        two_src      = v.two;
    endtask

    task automatic applyStimulus(input vec_t v);
        drive(v);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic eh, input logic [15:0] eb,
                               input logic eo, input logic eu);
        total++;
        if (hazard_detected !== eh) begin
            bad++;
            $display("[TB] FAIL %s hazard_detected got=%0b want=%0b", name, hazard_detected, eh);
        end
        total++;
        if (busy_mask !== eb) begin
            bad++;
            $display("[TB] FAIL %s busy_mask got=%04h want=%04h", name, busy_mask, eb);
        end
        total++;
        if (overflow_err !== eo) begin
            bad++;
            $display("[TB] FAIL %s overflow_err got=%0b want=%0b", name, overflow_err, eo);
        end
        total++;
        if (underflow_err !== eu) begin
            bad++;
            $display("[TB] FAIL %s underflow_err got=%0b want=%0b", name, underflow_err, eu);
        end
    endtask

    initial begin
        // Expected values are the state after the clock edge, with the row's src inputs still applied.
        vecs.push_back(mk("reset",            1, -1, -1, 5, 0, 0, 0, 16'h0000, 0, 0));
        vecs.push_back(mk("reset_hold",       1, -1, -1, 5, 3, 1, 0, 16'h0000, 0, 0));
        vecs.push_back(mk("idle_after_reset", 0, -1, -1, 5, 0, 0, 0, 16'h0000, 0, 0));
        vecs.push_back(mk("iss3",             0,  3, -1, 3, 0, 0, 1, 16'h0008, 0, 0));
        vecs.push_back(mk("wait3a",           0, -1, -1, 3, 0, 0, 1, 16'h0008, 0, 0));
        vecs.push_back(mk("wait3b",           0, -1, -1, 3, 0, 0, 1, 16'h0008, 0, 0));
        vecs.push_back(mk("ret3",             0, -1,  3, 3, 0, 0, 0, 16'h0000, 0, 0));
        vecs.push_back(mk("iss7_1",           0,  7, -1, 7, 0, 0, 1, 16'h0080, 0, 0));
        vecs.push_back(mk("iss7_2",           0,  7, -1, 7, 0, 0, 1, 16'h0080, 0, 0));
        vecs.push_back(mk("iss7_3",           0,  7, -1, 7, 0, 0, 1, 16'h0080, 0, 0));
        vecs.push_back(mk("iss7_ovf",         0,  7, -1, 7, 0, 0, 1, 16'h0080, 1, 0));
        vecs.push_back(mk("ret7_1",           0, -1,  7, 7, 0, 0, 1, 16'h0080, 1, 0));
        vecs.push_back(mk("ret7_2",           0, -1,  7, 7, 0, 0, 1, 16'h0080, 1, 0));
        vecs.push_back(mk("ret7_3",           0, -1,  7, 7, 0, 0, 0, 16'h0000, 1, 0));
        vecs.push_back(mk("ret7_unf",         0, -1,  7, 7, 0, 0, 0, 16'h0000, 1, 1));
        vecs.push_back(mk("reset_flags",      1, -1, -1, 7, 0, 0, 0, 16'h0000, 0, 0));
        vecs.push_back(mk("iss2",             0,  2, -1, 2, 0, 0, 1, 16'h0004, 0, 0));
        vecs.push_back(mk("iss2_ret2_at1",    0,  2,  2, 2, 0, 0, 1, 16'h0004, 0, 0));
        vecs.push_back(mk("ret2",             0, -1,  2, 2, 0, 0, 0, 16'h0000, 0, 0));
        vecs.push_back(mk("iss2_ret2_at0",    0,  2,  2, 2, 0, 0, 0, 16'h0000, 0, 0));
        vecs.push_back(mk("iss2_a",           0,  2, -1, 2, 0, 0, 1, 16'h0004, 0, 0));
        vecs.push_back(mk("iss2_b",           0,  2, -1, 2, 0, 0, 1, 16'h0004, 0, 0));
        vecs.push_back(mk("iss2_c",           0,  2, -1, 2, 0, 0, 1, 16'h0004, 0, 0));
        vecs.push_back(mk("iss2_ret2_atmax",  0,  2,  2, 2, 0, 0, 1, 16'h0004, 0, 0));
        vecs.push_back(mk("ret2_a",           0, -1,  2, 2, 0, 0, 1, 16'h0004, 0, 0));
        vecs.push_back(mk("ret2_b",           0, -1,  2, 2, 0, 0, 1, 16'h0004, 0, 0));
        vecs.push_back(mk("ret2_c",           0, -1,  2, 2, 0, 0, 0, 16'h0000, 0, 0));
        vecs.push_back(mk("iss6",             0,  6, -1, 6, 0, 0, 1, 16'h0040, 0, 0));
        vecs.push_back(mk("iss5_ret6",        0,  5,  6, 5, 0, 0, 1, 16'h0020, 0, 0));
        vecs.push_back(mk("iss9_two0",        0,  9, -1, 4, 9, 0, 0, 16'h0220, 0, 0));
        vecs.push_back(mk("src2_two1",        0, -1, -1, 4, 9, 1, 1, 16'h0220, 0, 0));
        vecs.push_back(mk("src2_two0",        0, -1, -1, 4, 9, 0, 0, 16'h0220, 0, 0));
        vecs.push_back(mk("ret5_src2",        0, -1,  5, 4, 9, 1, 1, 16'h0200, 0, 0));
        vecs.push_back(mk("iss1_a",           0,  1, -1, 1, 0, 0, 1, 16'h0202, 0, 0));
        vecs.push_back(mk("iss1_b",           0,  1, -1, 1, 0, 0, 1, 16'h0202, 0, 0));
        vecs.push_back(mk("iss8",             0,  8, -1, 1, 0, 0, 1, 16'h0302, 0, 0));
        vecs.push_back(mk("rst_with_iss1",    1,  1, -1, 1, 0, 0, 0, 16'h0000, 0, 0));
        vecs.push_back(mk("after_rst",        0, -1, -1, 1, 8, 1, 0, 16'h0000, 0, 0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i].name, vecs[i].eh, vecs[i].eb, vecs[i].eo, vecs[i].eu);
        end

        // An issue does not raise the hazard before its own edge.
        drive(mk("h_iss3", 0, 3, -1, 3, 0, 0, 0, 16'h0, 0, 0));
        #1;
        checkOutput("iss3_same_cycle", 1'b0, 16'h0000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("iss3_next_cycle", 1'b1, 16'h0008, 1'b0, 1'b0);
        applyStimulus(mk("h_idle_a", 0, -1, -1, 3, 0, 0, 0, 16'h0, 0, 0));
        applyStimulus(mk("h_idle_b", 0, -1, -1, 3, 0, 0, 0, 16'h0, 0, 0));

        // A retire does not drop the hazard before its own edge.
        drive(mk("h_ret3", 0, -1, 3, 3, 0, 0, 0, 16'h0, 0, 0));
        #1;
        checkOutput("ret3_same_cycle", 1'b1, 16'h0008, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("ret3_next_cycle", 1'b0, 16'h0000, 1'b0, 1'b0);

        // Events qualified off by wb_en or valid must not touch counters or flags.
        rst = 1'b0;
        issue_valid = 1'b1;  issue_wb_en = 1'b0;  issue_dest = 4'd4;
        retire_valid = 1'b1; retire_wb_en = 1'b0; retire_dest = 4'd5;
        src1 = 4'd4; src2 = 4'd5; two_src = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("wb_en_low", 1'b0, 16'h0000, 1'b0, 1'b0);
        issue_valid = 1'b0;  issue_wb_en = 1'b1;  issue_dest = 4'd4;
        retire_valid = 1'b0; retire_wb_en = 1'b1; retire_dest = 4'd4;
        @(posedge clk);
        #1;
        checkOutput("valid_low", 1'b0, 16'h0000, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/register_scoreboard.md
# register_scoreboard

Per-register pending-write tracker for the ARM pipeline. Instructions that write a register are recorded at issue from ID and cleared when their result is written back from WB. ID-stage source registers are checked against the recorded pending writes to raise a stall request. The block tracks destinations at the point they are produced and consumed, rather than comparing against the EXE/MEM destination fields, so it generalises to variable-latency memory stages.

## Interface

Parameters:
- NUM_REGS, 16: architectural registers tracked (R0..R15).
- CNT_W, 2: width of each per-register pending counter.
- MAX_PENDING, 3: saturation limit per register; must be ≤ 2^CNT_W − 1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous and active-high.
- issue_valid  input  1  an instruction leaves ID this cycle (low while stalled or flushed).
- issue_wb_en  input  1  the issuing instruction writes a register.
- issue_dest  input  4  destination register of the issuing instruction.
- retire_valid  input  1  an instruction completes WB this cycle.
- retire_wb_en  input  1  the retiring instruction wrote a register.
- retire_dest  input  4  destination register written back.
- src1  input  4  first ID-stage source register.
- src2  input  4  second ID-stage source register.
- two_src  input  1  src2 is a real operand this cycle.
- hazard_detected  output  1  stall request for ID; combinational from registered state and src inputs.
- busy_mask  output  16  bit r is high when counter[r] ≠ 0; registered.
- overflow_err  output  1  sticky flag: an issue occurred with counter already at MAX_PENDING.
- underflow_err  output  1  sticky flag: a retire occurred with counter already at 0.

## Operation

- State: NUM_REGS counters of CNT_W bits, plus two sticky error flags.
- Issue event: issue_valid && issue_wb_en. It increments counter[issue_dest].
- Retire event: retire_valid && retire_wb_en. It decrements counter[retire_dest].
- Same register, both events in the same cycle: counter is unchanged, and neither error flag is set. This holds even at 0 or MAX_PENDING.
- Different registers, both events in the same cycle: both updates are applied independently.
- Issue with counter at MAX_PENDING and no matching retire: counter holds at MAX_PENDING and overflow_err is set.
- Retire with counter at 0 and no matching issue: counter holds at 0 and underflow_err is set.
- Error flags clear only on rst.
- The hazard check uses registered counters only:
  - hazard = (counter[src1] ≠ 0) || (two_src && counter[src2] ≠ 0).
  - A retire in the current cycle does not suppress the hazard until the next cycle.
  - An issue in the current cycle does not raise the hazard until the next cycle.
- issue_valid must be deasserted by the pipeline whenever hazard_detected is high. The block does not gate issue itself.
- busy_mask is the registered OR-reduction of each counter, updated in the same edge as the counters.

## Timing

- Reset values:
  - all counters 0;
  - busy_mask 16'h0000;
  - overflow_err 0 and underflow_err 0;
  - hazard_detected 0 for any src inputs.
- rst has priority over any issue or retire event in the same cycle. Those events are discarded.
- Reset mid-operation discards all pending state. The pipeline must flush all in-flight instructions with the same rst.
- Update latency: an event at edge N is visible on busy_mask and hazard_detected from edge N onward, i.e. in cycle N+1.
- hazard_detected has no internal pipelining. It must settle within the ID cycle from the src and two_src inputs.
- Minimum in-flight depth for this pipeline: an instruction issued at edge N retires at edge N+3 (EXE, MEM, WB). Back-to-back writers to one register therefore need MAX_PENDING ≥ 3.

## Test plan

- Reset, then src1=5, two_src=0 → hazard_detected=0, busy_mask=0x0000, both error flags 0.
- Issue dest=3, then retire dest=3 three cycles later:
  - src1=3 gives hazard 1 in the cycles after the issue edge;
  - hazard drops to 0 in the cycle after the retire edge;
  - busy_mask bit 3 follows the same timing.
- Three issues to dest=7 on consecutive edges → counter 3, and a fourth issue sets overflow_err=1 with counter still 3. Then four retires to dest=7 → counter 0 after the third retire, and underflow_err=1 after the fourth.
- Simultaneous issue dest=2 and retire dest=2 with counter=1 → counter stays 1 and no error flag is set. Repeat with counter=0 → counter stays 0 and underflow_err stays 0.
- src1=4 (idle), src2=9 (pending):
  - two_src=0 → hazard_detected=0;
  - two_src=1 → hazard_detected=1.
- Counters at R1=2 and R8=1, then assert rst together with issue dest=1 → next cycle all counters 0, busy_mask=0x0000, and hazard_detected=0 for src1=1.
